stopwatch_lap_cu: RTL and testbench



---
 rtl/stopwatch_lap_cu.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_lap_cu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_cu.sv
// stopwatch_lap_cu
//   Lap/split control unit for the stopwatch. It turns four debounced button
//   pulses into the datapath's run enable and clear pulse. It also keeps a
//   small lap buffer and selects which time the display path shows.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   btn_runstop/clear/       single-cycle button pulses
//   btn_lap/recall           (priority runstop > clear > lap > recall)
//   i_msec/i_sec/i_min/i_hour  live time from the datapath
//   o_run_stop, o_clear      datapath run enable / one-cycle clear
//   o_msec/o_sec/o_min/o_hour  displayed time (live, split or recalled lap)
//   o_lap_cnt                number of valid lap entries (0..LAP_DEPTH)
//   o_lap_idx                lap entry shown while recalling
//   o_frozen                 display is not live (SPLIT or RECALL)
//   o_full                   lap buffer holds LAP_DEPTH entries
module stopwatch_lap_cu #(
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_runstop,
    input  logic                         btn_clear,
    input  logic                         btn_lap,
    input  logic                         btn_recall,
    input  logic [6:0]                   i_msec,
    input  logic [5:0]                   i_sec,
    input  logic [5:0]                   i_min,
    input  logic [4:0]                   i_hour,
    output logic                         o_run_stop,
    output logic                         o_clear,
    output logic [6:0]                   o_msec,
    output logic [5:0]                   o_sec,
    output logic [5:0]                   o_min,
    output logic [4:0]                   o_hour,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_cnt,
    output logic [$clog2(LAP_DEPTH)-1:0] o_lap_idx,
    output logic                         o_frozen,
    output logic                         o_full
);

    localparam int IW = $clog2(LAP_DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SPLIT,
        S_STOP,
        S_RECALL,
        S_CLEAR
    } state_t;

    state_t         state, state_nx;

    logic [23:0]    live_time;
    logic [23:0]    split_q;
    logic [23:0]    shown;
    logic [23:0]    lap_mem [LAP_DEPTH];
    logic [CW-1:0]  lap_cnt_q;
    logic [IW-1:0]  lap_idx_q;
    logic           full;

    // Exactly one winner per cycle; lower-priority pulses are dropped even
    // when the winner has no effect in the current state.
    logic win_rs, win_cl, win_lp, win_rc;

    logic do_capture, do_clear, do_recall_start, do_recall_step;

    assign live_time = {i_hour, i_min, i_sec, i_msec};
    assign full      = (lap_cnt_q == CW'(LAP_DEPTH));

    assign win_rs = btn_runstop;
    assign win_cl = btn_clear  & ~btn_runstop;
    assign win_lp = btn_lap    & ~btn_runstop & ~btn_clear;
    assign win_rc = btn_recall & ~btn_runstop & ~btn_clear & ~btn_lap;

    always_comb begin
        state_nx        = state;
        do_capture      = 1'b0;
        do_clear        = 1'b0;
        do_recall_start = 1'b0;
        do_recall_step  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (win_rs) begin
                    state_nx = S_RUN;
                end else if (win_cl) begin
                    state_nx = S_CLEAR;
                    do_clear = 1'b1;
                end
            end
            S_RUN, S_SPLIT: begin
                if (win_rs) begin
                    state_nx = S_STOP;
                end else if (win_lp) begin
                    state_nx   = S_SPLIT;
                    do_capture = 1'b1;
                end
            end
            S_STOP: begin
                if (win_rs) begin
                    state_nx = S_RUN;
                end else if (win_cl) begin
                    state_nx = S_CLEAR;
                    do_clear = 1'b1;
                end else if (win_rc && lap_cnt_q != '0) begin
                    state_nx        = S_RECALL;
                    do_recall_start = 1'b1;
                end
            end
            S_RECALL: begin
                // runstop/clear only leave recall; the pulse is consumed.
                if (win_rs || win_cl) begin
                    state_nx = S_STOP;
                end else if (win_rc) begin
                    do_recall_step = 1'b1;
                end
            end
            S_CLEAR: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            split_q   <= '0;
            lap_cnt_q <= '0;
            lap_idx_q <= '0;
        end else begin
            state <= state_nx;
            if (do_clear) begin
                split_q   <= '0;
                lap_cnt_q <= '0;
                lap_idx_q <= '0;
            end
            if (do_capture) begin
                split_q <= live_time;
                if (!full) begin
                    lap_cnt_q <= lap_cnt_q + CW'(1);
                end
            end
            if (do_recall_start) begin
                lap_idx_q <= '0;
            end else if (do_recall_step) begin
                if ({1'b0, lap_idx_q} == lap_cnt_q - CW'(1)) begin
                    lap_idx_q <= '0;
                end else begin
                    lap_idx_q <= lap_idx_q + IW'(1);
                end
            end
        end
    end

    // Lap storage carries no reset; entries at or beyond lap_cnt are never shown.
    always_ff @(posedge clk) begin
        if (!rst && do_capture && !full) begin
            lap_mem[lap_cnt_q[IW-1:0]] <= live_time;
        end
    end

    always_comb begin
        shown = live_time;
        case (state)
            S_SPLIT:  shown = split_q;
            S_RECALL: shown = lap_mem[lap_idx_q];
            default:  shown = live_time;
        endcase
    end

    assign {o_hour, o_min, o_sec, o_msec} = shown;

    assign o_run_stop = (state == S_RUN) || (state == S_SPLIT);
    assign o_clear    = (state == S_CLEAR);
    assign o_frozen   = (state == S_SPLIT) || (state == S_RECALL);
    assign o_lap_cnt  = lap_cnt_q;
    assign o_lap_idx  = lap_idx_q;
    assign o_full     = full;

endmodule

// File: tb/tb_stopwatch_lap_cu.sv
module tb_stopwatch_lap_cu;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_runstop = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0, btn_recall = 1'b0;
    logic [6:0] i_msec = '0;
    logic [5:0] i_sec = '0, i_min = '0;
    logic [4:0] i_hour = '0;
    logic       o_run_stop, o_clear, o_frozen, o_full;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [$clog2(D):0]   o_lap_cnt;
    logic [$clog2(D)-1:0] o_lap_idx;

    stopwatch_lap_cu #(.LAP_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .btn_runstop(btn_runstop), .btn_clear(btn_clear),
        .btn_lap(btn_lap), .btn_recall(btn_recall),
        .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .o_run_stop(o_run_stop), .o_clear(o_clear),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_lap_cnt(o_lap_cnt), .o_lap_idx(o_lap_idx),
        .o_frozen(o_frozen), .o_full(o_full)
    );

    always #5 clk = ~clk;

    // Behavioural reference: stopwatch mode, a queue of lap times, split value.
    typedef enum {M_IDLE, M_RUN, M_SPLIT, M_STOP, M_RECALL, M_CLEAR} mode_t;
    mode_t       mode = M_IDLE;
    logic [23:0] laps[$];
    logic [23:0] split_v = '0;
    int          idx = 0;

    int n_pass = 0, n_fail = 0, n_total = 0;

    function automatic logic [23:0] rnd_time();
        return {5'($urandom_range(23)), 6'($urandom_range(59)),
                6'($urandom_range(59)), 7'($urandom_range(99))};
    endfunction

    task automatic model_edge(input bit r, rs, cl, lp, rc, input logic [23:0] t);
        if (r) begin
            mode = M_IDLE; laps.delete(); split_v = '0; idx = 0;
            return;
        end
        // Only the highest-priority pulse is considered.
        if (rs) begin cl = 0; lp = 0; rc = 0; end
        else if (cl) begin lp = 0; rc = 0; end
        else if (lp) rc = 0;
        case (mode)
            M_IDLE:
                if (rs) mode = M_RUN;
                else if (cl) begin mode = M_CLEAR; laps.delete(); split_v = '0; idx = 0; end
            M_RUN, M_SPLIT:
                if (rs) mode = M_STOP;
                else if (lp) begin
                    mode = M_SPLIT;
                    split_v = t;
                    if (laps.size() < D) laps.push_back(t);
                end
            M_STOP:
                if (rs) mode = M_RUN;
                else if (cl) begin mode = M_CLEAR; laps.delete(); split_v = '0; idx = 0; end
                else if (rc && laps.size() > 0) begin mode = M_RECALL; idx = 0; end
            M_RECALL:
                if (rs || cl) mode = M_STOP;
                else if (rc) idx = (idx + 1) % laps.size();
            M_CLEAR: mode = M_IDLE;
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic [23:0] t);
        logic [23:0] exp_disp;
        exp_disp = t;
        if (mode == M_SPLIT) exp_disp = split_v;
        if (mode == M_RECALL) exp_disp = laps[idx];
        chk("run_stop", 32'(o_run_stop), 32'(mode == M_RUN || mode == M_SPLIT));
        chk("clear",    32'(o_clear),    32'(mode == M_CLEAR));
        chk("frozen",   32'(o_frozen),   32'(mode == M_SPLIT || mode == M_RECALL));
        chk("display",  32'({o_hour, o_min, o_sec, o_msec}), 32'(exp_disp));
        if (mode != M_CLEAR) begin
            chk("lap_cnt", 32'(o_lap_cnt), 32'(laps.size()));
            chk("full",    32'(o_full),    32'(laps.size() == D));
            chk("lap_idx", 32'(o_lap_idx), 32'(idx));
        end
    endtask

    // One clock: drive at negedge, reference updates at posedge, check #1 later.
    task automatic tick(input bit r, rs, cl, lp, rc, input logic [23:0] t);
        @(negedge clk);
        rst = r; btn_runstop = rs; btn_clear = cl; btn_lap = lp; btn_recall = rc;
        {i_hour, i_min, i_sec, i_msec} = t;
        @(posedge clk);
        model_edge(r, rs, cl, lp, rc, t);
        #1;
        check_all(t);
    endtask

    task automatic press(input bit rs, cl, lp, rc);
        tick(1'b0, rs, cl, lp, rc, rnd_time());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) press(0, 0, 0, 0);
    endtask

    initial begin
        logic [23:0] tt [5];
        tt[0] = {5'd0, 6'd1, 6'd23, 7'd45};
        tt[1] = {5'd0, 6'd2, 6'd0,  7'd7};
        tt[2] = {5'd1, 6'd0, 6'd59, 7'd99};
        tt[3] = {5'd3, 6'd33, 6'd3, 7'd0};
        tt[4] = {5'd23, 6'd59, 6'd59, 7'd98};

        // 1. reset, run at cycle 5, stop at cycle 20
        tick(1, 0, 0, 0, 0, rnd_time());
        tick(1, 1, 1, 1, 1, rnd_time());
        idle(4);
        press(1, 0, 0, 0);
        idle(14);
        press(1, 0, 0, 0);
        idle(2);

        // 2. split capture with changing live time, then stop -> live
        press(1, 0, 0, 0);
        idle(3);
        tick(0, 0, 0, 1, 0, tt[0]);
        idle(5);
        press(1, 0, 0, 0);
        idle(2);
        press(0, 1, 0, 0);
        idle(2);

        // 3. overflow: five laps, stop, recall five times
        press(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            idle(2);
            tick(0, 0, 0, 1, 0, tt[k]);
        end
        idle(2);
        press(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            press(0, 0, 0, 1);
            idle(1);
        end
        press(0, 1, 0, 0);     // leaves recall without clearing
        idle(1);

        // 4. clear from stop, recall ignored in idle, clear ignored in run
        press(0, 1, 0, 0);
        idle(2);
        press(0, 0, 0, 1);
        idle(1);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        idle(2);

        // 5. simultaneous pulses
        press(0, 0, 1, 0);
        idle(1);
        press(1, 0, 1, 0);
        idle(1);
        press(0, 1, 0, 1);
        idle(2);

        // 6. reset mid-recall at index 2
        press(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 1, 0, rnd_time());
            idle(1);
        end
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        tick(1, 0, 0, 1, 1, rnd_time());
        idle(3);

        // randomized pulse stream
        for (int k = 0; k < 600; k++) begin
            tick($urandom_range(79) == 0,
                 $urandom_range(7) == 0, $urandom_range(9) == 0,
                 $urandom_range(3) == 0, $urandom_range(3) == 0,
                 rnd_time());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
